clk_freq_meter: RTL and testbench

- Measuring end of the fractional clock divider.
- Samples an asynchronous divided/external clock (`clk_in`) in the `clk_src` domain.
- Measures its period as fixed-point `clk_src` cycles, averaged over 2^WINDOW_BITS `clk_in` periods.
- Flags lock against an expected frequency, and flags timeout when `clk_in` stops. Used to check on hardware that divider outputs and bus clocks (e.g. 3.579545 MHz) are on target.

---
 rtl/clk_freq_meter.sv | 154 +++++++++++++++
 tb/tb_clk_freq_meter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_freq_meter.sv
// clk_freq_meter: measures the period of an asynchronous clock (clk_in) in
// clk_src cycles, averaged over 2^WINDOW_BITS clk_in periods. The result is
// fixed point with WINDOW_BITS fractional bits. The block also flags lock
// against an expected frequency and flags a timeout when clk_in stops.
module clk_freq_meter #(
  parameter real CLK_SRC        = 125.0,
  parameter real CLK_EXP        = 3.579545,
  parameter int  WINDOW_BITS    = 8,
  parameter int  CNT_WIDTH      = 24,
  parameter int  TOL_TICKS      = 64,
  parameter int  TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_src,
  input  logic                 reset,
  input  logic                 clk_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 valid,
  output logic                 locked,
  output logic                 timeout
);

  // Expected window length in clk_src cycles, which is floor(ratio * 2^WINDOW_BITS).
  localparam int EXP_INT = $rtoi(CLK_SRC / CLK_EXP * real'(2 ** WINDOW_BITS));
  localparam logic [CNT_WIDTH-1:0] EXP_PERIOD = CNT_WIDTH'(EXP_INT);
  localparam logic [CNT_WIDTH-1:0] TOL        = CNT_WIDTH'(TOL_TICKS);
  localparam int                   IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0]    IDLE_MAX   = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0]    IDLE_LAST  = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic                   hist_q, hist_d;
  logic [WINDOW_BITS-1:0] ecnt_q, ecnt_d;
  logic [CNT_WIDTH-1:0]   win_q, win_d;
  logic [IDLE_W-1:0]      idle_q, idle_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   locked_q, locked_d;
  logic                   timeout_q, timeout_d;

  logic                   edge_det;
  logic                   idle_hit;
  logic                   win_full;
  logic [CNT_WIDTH-1:0]   diff;
  logic                   in_tol;

  // A rising edge is seen when the synchronised level is high and its history is low.
  assign edge_det = sync2_q & ~hist_q;
  // The idle threshold only counts if no edge arrives in the same cycle.
  assign idle_hit = ~edge_det & (idle_q == IDLE_LAST);
  assign win_full = (win_q == {CNT_WIDTH{1'b1}});
  assign diff     = (win_q > EXP_PERIOD) ? (win_q - EXP_PERIOD) : (EXP_PERIOD - win_q);
  assign in_tol   = (diff <= TOL);

  assign period  = period_q;
  assign valid   = valid_q;
  assign locked  = locked_q;
  assign timeout = timeout_q;

  // Next-state logic: synchroniser, idle watchdog, window FSM and result capture.
  always_comb begin
    state_d   = state_q;
    sync1_d   = clk_in;
    sync2_d   = sync1_q;
    hist_d    = sync2_q;
    ecnt_d    = ecnt_q;
    win_d     = win_q;
    idle_d    = idle_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;

    if (edge_det) begin
      idle_d    = '0;
      timeout_d = 1'b0;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + 1'b1;
    end

    case (state_q)
      WAIT_FIRST: begin
        if (edge_det) begin
          win_d   = CNT_WIDTH'(1);
          ecnt_d  = '0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (!win_full) begin
          win_d = win_q + 1'b1;
        end
        if (edge_det) begin
          if (ecnt_q == {WINDOW_BITS{1'b1}}) begin
            // The closing edge also opens the next window, so there is no dead time.
            period_d = win_q;
            valid_d  = 1'b1;
            locked_d = in_tol;
            win_d    = CNT_WIDTH'(1);
            ecnt_d   = '0;
          end else begin
            ecnt_d = ecnt_q + 1'b1;
          end
        end
      end
      default: state_d = WAIT_FIRST;
    endcase

    // A lost clock or an impossibly long window abandons the measurement in progress.
    if (idle_hit || (state_q == MEASURE && win_full)) begin
      timeout_d = 1'b1;
      locked_d  = 1'b0;
      valid_d   = 1'b0;
      period_d  = period_q;
      state_d   = WAIT_FIRST;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_src) begin
    if (reset) begin
      state_q   <= WAIT_FIRST;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      hist_q    <= 1'b0;
      ecnt_q    <= '0;
      win_q     <= '0;
      idle_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      hist_q    <= hist_d;
      ecnt_q    <= ecnt_d;
      win_q     <= win_d;
      idle_q    <= idle_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_clk_freq_meter.sv
// Testbench for clk_freq_meter: clk_in is generated cycle by cycle from the
// clk_src domain, and a timestamp-based reference model predicts every output.
module tb_clk_freq_meter;

  localparam int CW    = 24;
  localparam int EXP_P = 8939;
  localparam int TOL   = 64;
  localparam int TO    = 1024;
  localparam int NWIN  = 256;
  localparam longint FR_N = 125000000;
  localparam longint FR_D = 3579545;

  logic          clk_src = 1'b0;
  logic          reset   = 1'b1;
  logic          clk_in  = 1'b0;
  logic [CW-1:0] period;
  logic          valid;
  logic          locked;
  logic          timeout;

  clk_freq_meter dut (
    .clk_src (clk_src),
    .reset   (reset),
    .clk_in  (clk_in),
    .period  (period),
    .valid   (valid),
    .locked  (locked),
    .timeout (timeout)
  );

  always #4 clk_src = ~clk_src;

  int compared = 0;
  int mism     = 0;

  // Reference model state. All times are clk_src posedge indices.
  int  t = 0;
  int  pend[$];
  logic prev_in = 1'b0;
  int  m_last_edge = 0;
  bit  m_meas = 0;
  int  m_start = 0;
  int  m_n = 0;
  int  m_period = 0;
  bit  m_valid = 0;
  bit  m_locked = 0;
  bit  m_timeout = 0;

  // Observations that the directed checks use.
  int  vt[$];
  int  vp[$];
  int  vl[$];
  int  last_rise = 0;
  logic prev_to = 1'b0;
  int  to_rise = -1;
  int  to_fall = -1;
  bit  to_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  endtask

  // Drive one clk_src cycle, advance the model, and check every output.
  task automatic step(input logic cin, input logic rst);
    bit edge_now;
    int d;
    clk_in = cin;
    reset  = rst;
    @(posedge clk_src);
    t++;
    m_valid  = 0;
    edge_now = 0;
    if (rst) begin
      m_period = 0; m_locked = 0; m_timeout = 0; m_meas = 0;
      m_last_edge = t;
      pend.delete();
    end else begin
      if (cin && !prev_in) begin
        pend.push_back(t + 2);
        last_rise = t;
      end
      if (pend.size() > 0 && pend[0] == t) begin
        edge_now = 1;
        void'(pend.pop_front());
      end
      if (edge_now) begin
        m_timeout = 0;
        if (!m_meas) begin
          m_meas = 1; m_start = t; m_n = 0;
        end else begin
          m_n++;
          if (m_n == NWIN) begin
            m_period = t - m_start;
            m_valid  = 1;
            d = m_period - EXP_P;
            if (d < 0) d = -d;
            m_locked = (d <= TOL);
            m_start  = t;
            m_n      = 0;
          end
        end
        m_last_edge = t;
      end else if (t - m_last_edge == TO) begin
        m_timeout = 1; m_locked = 0; m_meas = 0;
      end
    end
    prev_in = rst ? 1'b0 : cin;
    #1;
    chk("period",  32'(period),  32'(m_period));
    chk("valid",   32'(valid),   32'(m_valid));
    chk("locked",  32'(locked),  32'(m_locked));
    chk("timeout", 32'(timeout), 32'(m_timeout));
    if (valid === 1'b1) begin
      vt.push_back(t);
      vp.push_back(int'(period));
      vl.push_back(int'(locked));
    end
    if (timeout === 1'b1 && prev_to === 1'b0) to_rise = t;
    if (timeout === 1'b0 && prev_to === 1'b1) to_fall = t;
    if (timeout === 1'b1) to_seen = 1;
    prev_to = timeout;
    if (mism > 40) finish_run();
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic run_clk(input int per, input int hi, input int nper);
    for (int k = 0; k < nper; k++)
      for (int c = 0; c < per; c++) step(c < hi, 1'b0);
  endtask

  // Fractional divider 125/3.579545: period k lasts floor((k+1)N/D)-floor(kN/D) cycles.
  task automatic run_frac(input longint k0, input int nper);
    longint len;
    for (longint k = k0; k < k0 + nper; k++) begin
      len = ((k + 1) * FR_N) / FR_D - (k * FR_N) / FR_D;
      for (longint c = 0; c < len; c++) step(c < len / 2, 1'b0);
    end
  endtask

  initial begin
    int first_act;
    int hi;
    int stop_n;

    // Reset state
    do_reset(3);
    chk("reset_period", 32'(period), 32'd0);
    chk("reset_valid",  32'(valid),  32'd0);

    // Period 35: first valid 256 periods after the first edge, then every 8960 cycles
    run_idle($urandom_range(5, 50));
    vt.delete(); vp.delete(); vl.delete();
    first_act = t + 3;
    hi = $urandom_range(17, 18);
    run_clk(35, hi, 2 * NWIN + 2);
    chk("p35_valid_count_ok", 32'(vt.size() >= 2), 32'd1);
    if (vt.size() >= 2) begin
      chk("p35_first_valid_delay", 32'(vt[0] - first_act), 32'd8960);
      chk("p35_period", 32'(vp[0]), 32'd8960);
      chk("p35_locked", 32'(vl[0]), 32'd1);
      chk("p35_spacing", 32'(vt[1] - vt[0]), 32'd8960);
    end
    $display("p35: %0d valids, first period %0d", vt.size(), (vp.size() > 0) ? vp[0] : -1);

    // Period 34 is outside tolerance
    do_reset(2);
    run_idle($urandom_range(5, 50));
    vt.delete(); vp.delete(); vl.delete();
    run_clk(34, 17, NWIN + 4);
    chk("p34_valid_count", 32'(vt.size()), 32'd1);
    if (vt.size() >= 1) begin
      chk("p34_period", 32'(vp[0]), 32'd8704);
      chk("p34_locked", 32'(vl[0]), 32'd0);
    end
    $display("p34: %0d valids", vt.size());

    // Dithered fractional divider stays within 8939 +/- 2 and locked
    do_reset(2);
    vt.delete(); vp.delete(); vl.delete();
    run_frac(longint'($urandom_range(0, 100000)), 2 * NWIN + 4);
    chk("frac_valid_count", 32'(vt.size()), 32'd2);
    foreach (vp[i]) begin
      chk("frac_period_in_range", 32'(vp[i] >= EXP_P - 2 && vp[i] <= EXP_P + 2), 32'd1);
      chk("frac_locked", 32'(vl[i]), 32'd1);
    end
    $display("frac: %0d valids", vt.size());

    // clk_in stops mid-window: timeout after exactly 1024 cycles, no valid
    do_reset(2);
    stop_n = $urandom_range(10, 150);
    run_clk(35, 17, NWIN + 2 + stop_n);
    chk("to_locked_before", 32'(locked), 32'd1);
    vt.delete(); vp.delete(); vl.delete();
    to_rise = -1;
    run_idle(1100);
    chk("to_latency", 32'(to_rise - (last_rise + 2)), 32'd1024);
    chk("to_level", 32'(timeout), 32'd1);
    chk("to_locked", 32'(locked), 32'd0);
    chk("to_no_valid", 32'(vt.size()), 32'd0);
    to_fall = -1;
    first_act = t + 3;
    run_clk(35, 17, NWIN + 2);
    chk("to_clear_time", 32'(to_fall), 32'(first_act));
    chk("to_restart_valid_count", 32'(vt.size()), 32'd1);
    if (vt.size() >= 1) chk("to_restart_period", 32'(vp[0]), 32'd8960);
    $display("timeout: rise after %0d cycles", to_rise - (last_rise + 2));

    // Reset for one cycle at edge 100 of a window discards the partial measurement
    run_clk(35, 17, 100);
    do_reset(1);
    chk("mid_reset_period", 32'(period), 32'd0);
    chk("mid_reset_locked", 32'(locked), 32'd0);
    vt.delete(); vp.delete(); vl.delete();
    first_act = t + 3;
    run_clk(35, 17, NWIN + 2);
    chk("mid_reset_valid_count", 32'(vt.size()), 32'd1);
    if (vt.size() >= 1) chk("mid_reset_delay", 32'(vt[0] - first_act), 32'd8960);
    $display("mid reset: %0d valids", vt.size());

    // Single-cycle pulses at exactly 1024-cycle spacing: edge wins at the threshold
    do_reset(2);
    to_seen = 0;
    for (int p = 0; p < 6; p++) begin
      step(1'b1, 1'b0);
      run_idle(TO - 1);
    end
    chk("glitch_no_timeout", 32'(to_seen), 32'd0);
    $display("glitch: timeout seen %0d", to_seen);

    finish_run();
  end

endmodule
